// File: rtl/rx_frame_pkg.sv
// Shared types and default sizing for the RX frame controller.
// The idle-flush feature is enabled by defining RX_FRAME_TIMEOUT_EN.
package rx_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } rx_state_e;

  localparam int DEF_FRAME_BYTES    = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1000;
  localparam int DEF_OVF_CNT_W      = 8;

  function automatic int width_for(input int max_value);
    return $clog2(max_value + 1);
  endfunction

  // Widths for the default configuration; the modules derive their own from parameters.
  localparam int IDX_W = width_for(DEF_FRAME_BYTES);
  localparam int TMR_W = width_for(DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/rx_frame_ctrl_timer.sv
// Idle timer for partial-frame flushing: reloads on clear, counts down while enabled.
// Only instantiated by rx_frame_ctrl when RX_FRAME_TIMEOUT_EN is defined.
module rx_idle_timer
  import rx_frame_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = width_for(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= LOAD_VAL;
    end else if (enable && cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  // Terminal count: the last idle cycle of the window, so the owner acts on this edge.
  assign expire = enable && !clear && (cnt == ONE);

endmodule

// File: rtl/rx_frame_ctrl.sv
// Packs the UART RX byte stream into FRAME_BYTES-byte frames behind a valid/ready handshake.
// Define RX_FRAME_TIMEOUT_EN to flush partial frames after TIMEOUT_CYCLES idle cycles.
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter int FRAME_BYTES    = DEF_FRAME_BYTES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int OVF_CNT_W      = DEF_OVF_CNT_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_valid,
  output logic [8*FRAME_BYTES-1:0]         frame_data,
  output logic [$clog2(FRAME_BYTES+1)-1:0] frame_len,
  output logic                             frame_valid,
  input  logic                             frame_ready,
  output logic [OVF_CNT_W-1:0]             overflow_cnt,
  output logic                             busy
);

  localparam int LEN_W  = width_for(FRAME_BYTES);
  localparam int LANE_W = $clog2(FRAME_BYTES);
  localparam logic [LEN_W-1:0]  FULL_LEN = LEN_W'(FRAME_BYTES);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [LANE_W-1:0] TOP_LANE = LANE_W'(FRAME_BYTES - 1);
  localparam logic [OVF_CNT_W-1:0] OVF_ONE = OVF_CNT_W'(1);

  if (FRAME_BYTES < 2 || FRAME_BYTES > 64 || TIMEOUT_CYCLES < 1 || OVF_CNT_W < 1) begin : g_bad_cfg
    $error("rx_frame_ctrl: unsupported parameter combination");
  end

  rx_state_e                  state;
  logic [LEN_W-1:0]           idx;
  logic [LEN_W-1:0]           idx_next;
  logic [FRAME_BYTES-1:0][7:0] lanes;
  logic [LANE_W-1:0]          wr_lane;
  logic                       timeout;

  // Byte k lives in lanes[FRAME_BYTES-1-k] so the first byte lands in the MSB lane.
  assign wr_lane    = TOP_LANE - idx[LANE_W-1:0];
  assign idx_next   = idx + LEN_ONE;
  assign frame_data = lanes;

`ifdef RX_FRAME_TIMEOUT_EN
  rx_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_valid),
    .enable (state == FILL && !rx_valid),
    .expire (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      lanes        <= '0;
      frame_len    <= '0;
      frame_valid  <= 1'b0;
      overflow_cnt <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid) begin
            lanes[FRAME_BYTES-1] <= rx_data;
            idx                  <= LEN_ONE;
            state                <= FILL;
            busy                 <= 1'b1;
          end
        end

        FILL: begin
          if (rx_valid) begin
            lanes[wr_lane] <= rx_data;
            idx            <= idx_next;
            if (idx_next == FULL_LEN) begin
              state       <= HOLD;
              frame_valid <= 1'b1;
              frame_len   <= FULL_LEN;
            end
          end else if (timeout) begin
            // Partial flush: unwritten lanes are already zero from the last clear.
            state       <= HOLD;
            frame_valid <= 1'b1;
            frame_len   <= idx;
          end
        end

        HOLD: begin
          if (frame_ready) begin
            frame_valid <= 1'b0;
            frame_len   <= '0;
            lanes       <= '0;
            if (rx_valid) begin
              lanes[FRAME_BYTES-1] <= rx_data;
              idx                  <= LEN_ONE;
              state                <= FILL;
            end else begin
              idx   <= '0;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (rx_valid && overflow_cnt != '1) begin
            overflow_cnt <= overflow_cnt + OVF_ONE;
          end
        end

        default: begin
          state       <= IDLE;
          idx         <= '0;
          frame_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: stimulus pushes expected frames, a monitor checks them.
module tb_rx_frame_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [127:0] frame_data;
  logic [4:0]   frame_len;
  logic         frame_valid;
  logic         frame_ready;
  logic [7:0]   overflow_cnt;
  logic         busy;

  typedef struct packed {
    logic [127:0] data;
    logic [4:0]   len;
  } frame_t;

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  rx_frame_ctrl #(
    .FRAME_BYTES    (16),
    .TIMEOUT_CYCLES (20),
    .OVF_CNT_W      (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_data   (frame_data),
    .frame_len    (frame_len),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .overflow_cnt (overflow_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Frame of n consecutive bytes starting at 'first', remaining lanes zero.
  function automatic frame_t mk_run(input logic [7:0] first, input int n);
    frame_t f;
    f.data = '0;
    for (int k = 0; k < n; k++)
      f.data[8*(16-k)-1 -: 8] = 8'(first + k);
    f.len = 5'(n);
    return f;
  endfunction

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_run(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) send(8'(first + i));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every presented frame must match the head of the scoreboard; pop on handshake.
  always @(negedge clk) begin
    if (!rst && frame_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame: got frame_data 0x%0h len %0d, want no frame", frame_data, frame_len);
      end else begin
        check("frame_data", frame_data, exp_q[0].data);
        check("frame_len", 128'(frame_len), 128'(exp_q[0].len));
        if (frame_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    frame_t f;
    rst         = 1'b1;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    frame_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_frame_valid", 128'(frame_valid), 0);
    check("rst_frame_len", 128'(frame_len), 0);
    check("rst_frame_data", frame_data, 0);
    check("rst_overflow", 128'(overflow_cnt), 0);
    check("rst_busy", 128'(busy), 0);

    // 1: straight frame, consumer always ready
    frame_ready = 1'b1;
    exp_q.push_back('{data: 128'h000102030405060708090A0B0C0D0E0F, len: 5'd16});
    send_run(8'h00, 16);
    @(negedge clk);
    check("t1_valid_after_last", 128'(frame_valid), 1);
    tick(1);
    @(negedge clk);
    check("t1_valid_one_cycle", 128'(frame_valid), 0);
    check("t1_busy_idle", 128'(busy), 0);

    // 2: held frame, three dropped bytes, then release
    frame_ready = 1'b0;
    exp_q.push_back(mk_run(8'h20, 16));
    send_run(8'h20, 16);
    send(8'hEE);
    send(8'hEF);
    send(8'hF0);
    @(negedge clk);
    check("t2_overflow", 128'(overflow_cnt), 3);
    check("t2_busy_hold", 128'(busy), 1);
    tick(1);
    frame_ready = 1'b1;
    tick(1);
    @(negedge clk);
    check("t2_valid_released", 128'(frame_valid), 0);
    check("t2_busy_idle", 128'(busy), 0);

    // 3: handshake and new byte in the same cycle
    frame_ready = 1'b0;
    exp_q.push_back(mk_run(8'h30, 16));
    send_run(8'h30, 16);
    frame_ready = 1'b1;
    send(8'hA5);
    @(negedge clk);
    check("t3_lane0_next", frame_data, {8'hA5, 120'h0});
    check("t3_overflow_same", 128'(overflow_cnt), 3);
    check("t3_valid_low", 128'(frame_valid), 0);
    check("t3_busy_fill", 128'(busy), 1);
    f = mk_run(8'h10, 15);
    f.data = {8'hA5, f.data[127:8]};
    f.len  = 5'd16;
    exp_q.push_back(f);
    send_run(8'h10, 15);
    @(negedge clk);
    check("t3_second_valid", 128'(frame_valid), 1);
    tick(1);

    // 4: overflow saturation
    frame_ready = 1'b0;
    exp_q.push_back(mk_run(8'h40, 16));
    send_run(8'h40, 16);
    repeat (251) send(8'hDD);
    @(negedge clk);
    check("t4_overflow_254", 128'(overflow_cnt), 254);
    repeat (49) send(8'hDD);
    @(negedge clk);
    check("t4_overflow_sat", 128'(overflow_cnt), 255);
    tick(1);
    frame_ready = 1'b1;
    tick(1);
    @(negedge clk);
    check("t4_busy_idle", 128'(busy), 0);

    // 5: partial frame then idle
`ifdef RX_FRAME_TIMEOUT_EN
    exp_q.push_back(mk_run(8'h50, 5));
    send_run(8'h50, 5);
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      check($sformatf("t5_timeout_valid_%0d", i), 128'(frame_valid), 128'(i == 20));
    end
    tick(1);
    @(negedge clk);
    check("t5_busy_idle", 128'(busy), 0);
`else
    send_run(8'h50, 5);
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      check("t5_no_flush", 128'(frame_valid), 0);
    end
    check("t5_busy_waiting", 128'(busy), 1);
    exp_q.push_back(mk_run(8'h50, 16));
    send_run(8'h55, 11);
    @(negedge clk);
    check("t5_full_valid", 128'(frame_valid), 1);
    tick(1);
`endif

    // 6: reset mid-frame, then a clean frame
    send_run(8'h60, 7);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_busy", 128'(busy), 0);
    check("t6_valid", 128'(frame_valid), 0);
    check("t6_data_cleared", frame_data, 0);
    check("t6_overflow_cleared", 128'(overflow_cnt), 0);
    exp_q.push_back(mk_run(8'h70, 16));
    send_run(8'h70, 16);
    @(negedge clk);
    check("t6_clean_valid", 128'(frame_valid), 1);
    tick(3);

    @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
